alarm_unit: RTL

Alarm stage downstream of the time counters in the FPGA clock. It holds an HH:MM alarm setpoint in BCD and lets the user edit that setpoint with the debounced button-release pulses. While armed, it compares the setpoint against live counter digits and runs a ring/snooze state machine that gates the display-rate tone onto a buzzer pin. Its setpoint digits and field-select outputs feed the display mux and blink logic alongside the time counters.

---
 rtl/alarm_unit_pkg.sv | 32 +++
 rtl/alarm_setpoint.sv | 59 +++++
 rtl/alarm_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/alarm_unit_pkg.sv
// Shared definitions for the alarm stage: FSM states, field-select codes
// and BCD limits of the hour/minute setpoint.
package alarm_unit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_RING     = 3'd3,
    ST_SNOOZE   = 3'd4
  } alarm_state_t;

  localparam logic [1:0] FIELD_NONE = 2'b00;
  localparam logic [1:0] FIELD_HOUR = 2'b01;
  localparam logic [1:0] FIELD_MIN  = 2'b10;

  localparam logic [1:0] HOUR_TENS_MAX  = 2'd2;
  localparam logic [3:0] HOUR_UNITS_TOP = 4'd3;
  localparam logic [2:0] MIN_TENS_MAX   = 3'd5;
  localparam logic [3:0] BCD_UNITS_MAX  = 4'd9;

  function automatic logic [1:0] field_of(input alarm_state_t s);
    logic [1:0] f;
    case (s)
      ST_SET_HOUR: f = FIELD_HOUR;
      ST_SET_MIN:  f = FIELD_MIN;
      default:     f = FIELD_NONE;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alarm_setpoint.sv
// Four BCD setpoint digits with wrap-around increments: hour 00..23,
// minute 00..59 (no carry from minute into hour).
module alarm_setpoint
  import alarm_unit_pkg::*;
(
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Inc_Hour,
  input  logic       i_Inc_Min,
  output logic [3:0] o_Units_Min,
  output logic [2:0] o_Tens_Min,
  output logic [3:0] o_Units_Hour,
  output logic [1:0] o_Tens_Hour
);

  logic [3:0] r_Units_Min;
  logic [2:0] r_Tens_Min;
  logic [3:0] r_Units_Hour;
  logic [1:0] r_Tens_Hour;

  // Hour digits: 23 wraps to 00, x9 carries into the tens digit.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Units_Hour <= 4'd0;
      r_Tens_Hour  <= 2'd0;
    end else if (i_Inc_Hour) begin
      if (r_Tens_Hour == HOUR_TENS_MAX && r_Units_Hour == HOUR_UNITS_TOP) begin
        r_Units_Hour <= 4'd0;
        r_Tens_Hour  <= 2'd0;
      end else if (r_Units_Hour == BCD_UNITS_MAX) begin
        r_Units_Hour <= 4'd0;
        r_Tens_Hour  <= r_Tens_Hour + 2'd1;
      end else begin
        r_Units_Hour <= r_Units_Hour + 4'd1;
      end
    end
  end

  // Minute digits: 59 wraps to 00.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Units_Min <= 4'd0;
      r_Tens_Min  <= 3'd0;
    end else if (i_Inc_Min) begin
      if (r_Units_Min == BCD_UNITS_MAX) begin
        r_Units_Min <= 4'd0;
        r_Tens_Min  <= (r_Tens_Min == MIN_TENS_MAX) ? 3'd0 : r_Tens_Min + 3'd1;
      end else begin
        r_Units_Min <= r_Units_Min + 4'd1;
      end
    end
  end

  assign o_Units_Min  = r_Units_Min;
  assign o_Tens_Min   = r_Tens_Min;
  assign o_Units_Hour = r_Units_Hour;
  assign o_Tens_Hour  = r_Tens_Hour;

endmodule

// File: rtl/alarm_unit.sv
// Alarm stage: setpoint editing, edge-detected match against live time and
// the ring/snooze state machine gating the tone onto the buzzer.
module alarm_unit
  import alarm_unit_pkg::*;
#(
  parameter int unsigned RING_TIMEOUT_SEC = 60,
  parameter int unsigned SNOOZE_MIN       = 5
) (
  input  logic       i_Clock,
  input  logic       i_Reset_n,
  input  logic       i_Enable_1Hz,
  input  logic       i_Tone,
  input  logic       i_Beep_Gate,
  input  logic       i_Set_Alarm,
  input  logic       i_Up,
  input  logic       i_Arm,
  input  logic [3:0] i_Units_Sec,
  input  logic [2:0] i_Tens_Sec,
  input  logic [3:0] i_Units_Min,
  input  logic [2:0] i_Tens_Min,
  input  logic [3:0] i_Units_Hour,
  input  logic [1:0] i_Tens_Hour,
  output logic [3:0] o_Alarm_Units_Min,
  output logic [2:0] o_Alarm_Tens_Min,
  output logic [3:0] o_Alarm_Units_Hour,
  output logic [1:0] o_Alarm_Tens_Hour,
  output logic [1:0] o_Set_Field,
  output logic       o_Armed,
  output logic       o_Ringing,
  output logic       o_Buzzer
);

  localparam logic [7:0] RING_LAST   = 8'(RING_TIMEOUT_SEC - 1);
  localparam logic [9:0] SNOOZE_LOAD = 10'(SNOOZE_MIN * 60);

  alarm_state_t r_State, w_Next_State;
  logic       r_Armed, w_Armed_Next;
  logic       r_Match_d;
  logic [7:0] r_Ring_Cnt, w_Ring_Cnt_Next;
  logic [9:0] r_Snooze_Cnt, w_Snooze_Cnt_Next;
  logic       r_Ringing, r_Buzzer;
  logic [1:0] r_Set_Field;
  logic       w_Match, w_Trigger, w_Dismiss;
  logic       w_Ringing_Next, w_Buzzer_Next;
  logic [1:0] w_Set_Field_Next;

  alarm_setpoint u_setpoint (
    .i_Clock      (i_Clock),
    .i_Reset_n    (i_Reset_n),
    .i_Inc_Hour   ((r_State == ST_SET_HOUR) && i_Up),
    .i_Inc_Min    ((r_State == ST_SET_MIN) && i_Up),
    .o_Units_Min  (o_Alarm_Units_Min),
    .o_Tens_Min   (o_Alarm_Tens_Min),
    .o_Units_Hour (o_Alarm_Units_Hour),
    .o_Tens_Hour  (o_Alarm_Tens_Hour)
  );

  assign w_Match = ({i_Tens_Hour, i_Units_Hour} == {o_Alarm_Tens_Hour, o_Alarm_Units_Hour})
                && ({i_Tens_Min, i_Units_Min} == {o_Alarm_Tens_Min, o_Alarm_Units_Min})
                && (i_Units_Sec == 4'd0) && (i_Tens_Sec == 3'd0);
  // Only the first matching cycle triggers, so one ring per matching minute.
  assign w_Trigger = w_Match && !r_Match_d && r_Armed && (r_State == ST_IDLE);
  assign w_Dismiss = i_Set_Alarm || i_Arm;

  // State, armed flag, counters and match history.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_State      <= ST_IDLE;
      r_Armed      <= 1'b0;
      r_Match_d    <= 1'b0;
      r_Ring_Cnt   <= 8'd0;
      r_Snooze_Cnt <= 10'd0;
    end else begin
      r_State      <= w_Next_State;
      r_Armed      <= w_Armed_Next;
      r_Match_d    <= w_Match;
      r_Ring_Cnt   <= w_Ring_Cnt_Next;
      r_Snooze_Cnt <= w_Snooze_Cnt_Next;
    end
  end

  // Next state; dismiss beats snooze beats timeout/expiry.
  always_comb begin
    w_Next_State      = r_State;
    w_Armed_Next      = r_Armed;
    w_Ring_Cnt_Next   = r_Ring_Cnt;
    w_Snooze_Cnt_Next = r_Snooze_Cnt;
    case (r_State)
      ST_IDLE: begin
        if (i_Arm) begin
          w_Armed_Next = !r_Armed;
        end else begin
          w_Armed_Next = r_Armed;
        end
        if (i_Set_Alarm) begin
          w_Next_State = ST_SET_HOUR;
        end else if (w_Trigger && !i_Arm) begin
          w_Next_State    = ST_RING;
          w_Ring_Cnt_Next = 8'd0;
        end else begin
          w_Next_State = ST_IDLE;
        end
      end
      ST_SET_HOUR: begin
        if (i_Set_Alarm) begin
          w_Next_State = ST_SET_MIN;
        end else begin
          w_Next_State = ST_SET_HOUR;
        end
      end
      ST_SET_MIN: begin
        if (i_Set_Alarm) begin
          w_Next_State = ST_IDLE;
          w_Armed_Next = 1'b1;
        end else begin
          w_Next_State = ST_SET_MIN;
        end
      end
      ST_RING: begin
        if (w_Dismiss) begin
          w_Next_State = ST_IDLE;
        end else if (i_Up) begin
          w_Next_State      = ST_SNOOZE;
          w_Snooze_Cnt_Next = SNOOZE_LOAD;
        end else if (i_Enable_1Hz) begin
          if (r_Ring_Cnt == RING_LAST) begin
            w_Next_State = ST_IDLE;
          end else begin
            w_Ring_Cnt_Next = r_Ring_Cnt + 8'd1;
          end
        end else begin
          w_Next_State = ST_RING;
        end
      end
      ST_SNOOZE: begin
        if (w_Dismiss) begin
          w_Next_State = ST_IDLE;
        end else if (i_Enable_1Hz) begin
          if (r_Snooze_Cnt == 10'd1) begin
            w_Next_State      = ST_RING;
            w_Ring_Cnt_Next   = 8'd0;
            w_Snooze_Cnt_Next = 10'd0;
          end else begin
            w_Snooze_Cnt_Next = r_Snooze_Cnt - 10'd1;
          end
        end else begin
          w_Next_State = ST_SNOOZE;
        end
      end
      default: begin
        w_Next_State = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so registered outputs align with it.
  always_comb begin
    w_Ringing_Next   = (w_Next_State == ST_RING);
    w_Buzzer_Next    = w_Ringing_Next && i_Tone && i_Beep_Gate;
    w_Set_Field_Next = field_of(w_Next_State);
  end

  // Registered outputs.
  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      r_Ringing   <= 1'b0;
      r_Buzzer    <= 1'b0;
      r_Set_Field <= FIELD_NONE;
    end else begin
      r_Ringing   <= w_Ringing_Next;
      r_Buzzer    <= w_Buzzer_Next;
      r_Set_Field <= w_Set_Field_Next;
    end
  end

  assign o_Armed     = r_Armed;
  assign o_Ringing   = r_Ringing;
  assign o_Buzzer    = r_Buzzer;
  assign o_Set_Field = r_Set_Field;

endmodule
